// File: rtl/seg_scroll_pkg.sv
// Shared definitions for the scrolling 7-segment driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the mode encodings, the bounce direction state type, the active-high
// hex glyph table (bit7=a .. bit1=g, bit0=dp) and the blank pattern.
package seg_scroll_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    typedef enum logic {
        BNC_UP = 1'b0,
        BNC_DN = 1'b1
    } bnc_state_t;

    // Entry [n] is the active-high glyph for nibble n; dp always off.
    localparam logic [15:0][7:0] HEX_GLYPH = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C,   // F E d C
        8'h3E, 8'hEE, 8'hF6, 8'hFE,   // b A 9 8
        8'hE0, 8'hBE, 8'hB6, 8'h66,   // 7 6 5 4
        8'hF2, 8'hDA, 8'h60, 8'hFC    // 3 2 1 0
    };

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Glyph for a nibble at the requested output polarity.
    function automatic logic [7:0] glyph_of(input logic [3:0] nibble, input logic active_low);
        return HEX_GLYPH[nibble] ^ {8{active_low}};
    endfunction

endpackage

// File: rtl/seg_scroll_ctrl_if.sv
// Control/display bundle between board logic and seg_scroll_ctrl.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or single-cycle strobes.
//
// master: board side (drives writes, length, mode, step; reads display).
// slave : seg_scroll_ctrl side.
// blink_mask exists only when SEG_SCROLL_BLINK_EN is defined.
interface seg_scroll_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int MSG_DEPTH  = 16
);
    localparam int AW = $clog2(MSG_DEPTH);

    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [3:0]              wr_data;
    logic [AW:0]             msg_len;
    logic [1:0]              mode;
    logic                    step;
`ifdef SEG_SCROLL_BLINK_EN
    logic [NUM_DIGITS-1:0]   blink_mask;
`endif
    logic [NUM_DIGITS*8-1:0] seg_out;
    logic [AW-1:0]           offset;
    logic                    tick;

`ifdef SEG_SCROLL_BLINK_EN
    modport master (output wr_en, wr_addr, wr_data, msg_len, mode, step, blink_mask,
                    input  seg_out, offset, tick);
    modport slave  (input  wr_en, wr_addr, wr_data, msg_len, mode, step, blink_mask,
                    output seg_out, offset, tick);
`else
    modport master (output wr_en, wr_addr, wr_data, msg_len, mode, step,
                    input  seg_out, offset, tick);
    modport slave  (input  wr_en, wr_addr, wr_data, msg_len, mode, step,
                    output seg_out, offset, tick);
`endif

endinterface

// File: rtl/hex7seg_dec.sv
// Hex nibble to 7-segment glyph decoder (0-F, dp off).
// Latency: combinational.
// Backpressure: none.
//
// Ports: nibble (4b value), active_low (1 = invert outputs), seg (bit7=a .. bit0=dp).
module hex7seg_dec
    import seg_scroll_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       active_low,
    output logic [7:0] seg
);

    assign seg = glyph_of(nibble, active_low);

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Scrolling driver for NUM_DIGITS 7-segment digits from a writable hex message buffer.
// Latency: offset moves on the tick edge; seg_out is registered one cycle behind offset/buffer.
// Backpressure: none; writes and steps are accepted every cycle.
//
// Ports: clk, rst (sync, active-high), bus (seg_scroll_ctrl_if.slave):
//   wr_en/wr_addr/wr_data buffer write, msg_len active length, mode (hold/left/right/bounce),
//   step manual advance in hold, seg_out digit k at [8k+7:8k], offset index on digit 0, tick.
// Optional: SEG_SCROLL_BLINK_EN adds bus.blink_mask and a blink phase toggled per tick.
module seg_scroll_ctrl
    import seg_scroll_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int MSG_DEPTH  = 16,
    parameter int TICK_DIV   = 5000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    seg_scroll_ctrl_if.slave  bus
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = AW + 5;          // room for offset + digit index up to 15
    localparam int CW = $clog2(TICK_DIV);
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [7:0] ZERO_GLYPH = HEX_GLYPH[0] ^ {8{POL}};

    // ---------------- prescaler ----------------
    logic [CW-1:0] pre_cnt;
    logic          tick;

    assign tick = (pre_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + CW'(1);
    end

    // ---------------- message buffer ----------------
    logic [3:0] msg_buf [MSG_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSG_DEPTH; i++) msg_buf[i] <= '0;
        end else if (bus.wr_en) begin
            msg_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // ---------------- effective length and bounce span ----------------
    logic [LW-1:0] eff_len;
    logic [LW-1:0] span;

    always_comb begin
        eff_len = bus.msg_len;
        if (bus.msg_len == '0)                    eff_len = LW'(1);
        else if (bus.msg_len > LW'(MSG_DEPTH))    eff_len = LW'(MSG_DEPTH);
    end

    assign span = (int'(eff_len) > NUM_DIGITS) ? LW'(int'(eff_len) - NUM_DIGITS) : '0;

    // ---------------- offset / bounce FSM ----------------
    logic [AW-1:0] offset_q, off_nxt;
    bnc_state_t    bnc_q, bnc_nxt;
    logic [LW-1:0] off_ext;
    logic [AW-1:0] off_inc, off_dec;

    assign off_ext = {1'b0, offset_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            offset_q <= '0;
            bnc_q    <= BNC_UP;
        end else begin
            offset_q <= off_nxt;
            bnc_q    <= bnc_nxt;
        end
    end

    always_comb begin
        off_nxt = offset_q;
        bnc_nxt = bnc_q;
        off_inc = (off_ext == eff_len - LW'(1)) ? '0 : offset_q + AW'(1);
        off_dec = (offset_q == '0) ? AW'(eff_len - LW'(1)) : offset_q - AW'(1);

        // Length shrink beats any tick/step movement.
        if (off_ext >= eff_len) begin
            off_nxt = '0;
            if (bus.mode == MODE_BOUNCE) bnc_nxt = BNC_UP;
        end else if (bus.mode == MODE_BOUNCE && off_ext > span) begin
            off_nxt = '0;
            bnc_nxt = BNC_UP;
        end else begin
            case (bus.mode)
                MODE_HOLD:  if (bus.step) off_nxt = off_inc;
                MODE_LEFT:  if (tick)     off_nxt = off_inc;
                MODE_RIGHT: if (tick)     off_nxt = off_dec;
                default: begin
                    if (tick) begin
                        if (span == '0) begin
                            off_nxt = '0;
                        end else if (bnc_q == BNC_UP) begin
                            if (off_ext < span) begin
                                off_nxt = offset_q + AW'(1);
                            end else begin
                                off_nxt = offset_q - AW'(1);
                                bnc_nxt = BNC_DN;
                            end
                        end else begin
                            if (offset_q != '0) begin
                                off_nxt = offset_q - AW'(1);
                            end else begin
                                off_nxt = AW'(1);
                                bnc_nxt = BNC_UP;
                            end
                        end
                    end
                end
            endcase
        end
    end

`ifdef SEG_SCROLL_BLINK_EN
    logic blink_phase;

    always_ff @(posedge clk) begin
        if (rst)       blink_phase <= 1'b0;
        else if (tick) blink_phase <= ~blink_phase;
    end
`endif

    // ---------------- display path ----------------
    logic [IW-1:0]           off_wide;
    logic [IW-1:0]           len_wide;
    logic [AW-1:0]           rd_idx  [NUM_DIGITS];
    logic [7:0]              dec_seg [NUM_DIGITS];
    logic [NUM_DIGITS*8-1:0] seg_nxt;
    logic [NUM_DIGITS*8-1:0] seg_q;

    assign off_wide = {5'b0, offset_q};
    assign len_wide = {4'b0, eff_len};

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        // True modulo so short messages repeat across the digit bank.
        assign rd_idx[k] = AW'((off_wide + IW'(k)) % len_wide);

        hex7seg_dec u_dec (
            .nibble     (msg_buf[rd_idx[k]]),
            .active_low (POL),
            .seg        (dec_seg[k])
        );

`ifdef SEG_SCROLL_BLINK_EN
        assign seg_nxt[k*8 +: 8] = (blink_phase && bus.blink_mask[k]) ? (SEG_BLANK ^ {8{POL}})
                                                                       : dec_seg[k];
`else
        assign seg_nxt[k*8 +: 8] = dec_seg[k];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) seg_q <= {NUM_DIGITS{ZERO_GLYPH}};
        else     seg_q <= seg_nxt;
    end

    assign bus.seg_out = seg_q;
    assign bus.offset  = offset_q;
    assign bus.tick    = tick;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Self-checking bench for seg_scroll_ctrl: directed scenarios then random traffic.
// A reference model predicts offset/tick/seg_out per cycle into a queue; a negedge
// monitor pops and compares.
module tb_seg_scroll_ctrl;

    localparam int ND = 4;
    localparam int MD = 16;
    localparam int TD = 4;
    localparam int AL = 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg_scroll_ctrl_if #(.NUM_DIGITS(ND), .MSG_DEPTH(MD)) bus ();

    seg_scroll_ctrl #(
        .NUM_DIGITS (ND),
        .MSG_DEPTH  (MD),
        .TICK_DIV   (TD),
        .ACTIVE_LOW (AL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]      off;
        logic            tck;
        logic [ND*8-1:0] seg;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model ----------------
    string glyph_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                              "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    int              m_buf [MD];
    int              m_off;
    bit              m_up;
    int              m_cnt;
    logic [ND*8-1:0] m_seg;

    function automatic logic [7:0] glyph(input int v);
        logic [7:0] g;
        string      s;
        g = 8'h00;
        s = glyph_str[v];
        for (int i = 0; i < s.len(); i++) g[7 - (int'(s[i]) - 97)] = 1'b1;
        if (AL != 0) g = ~g;
        return g;
    endfunction

    function automatic int eff_len(input int ml);
        if (ml == 0) return 1;
        if (ml > MD) return MD;
        return ml;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MD; i++) m_buf[i] = 0;
        m_off = 0;
        m_up  = 1'b1;
        m_cnt = 0;
        for (int k = 0; k < ND; k++) m_seg[k*8 +: 8] = glyph(0);
    endtask

    // One clock with the currently driven inputs: predict, wait edge, advance model.
    task automatic cycle();
        exp_t e;
        int   ml, md, we, wa, wd, st, L, S;
        bit   tk;
        ml = int'(bus.msg_len);
        md = int'(bus.mode);
        we = int'(bus.wr_en);
        wa = int'(bus.wr_addr);
        wd = int'(bus.wr_data);
        st = int'(bus.step);
        tk = (m_cnt == TD - 1);
        e.off = 4'(m_off);
        e.tck = tk;
        e.seg = m_seg;
        exp_q.push_back(e);
        @(posedge clk);
        L = eff_len(ml);
        S = (L > ND) ? L - ND : 0;
        for (int k = 0; k < ND; k++) m_seg[k*8 +: 8] = glyph(m_buf[(m_off + k) % L]);
        if (m_off >= L) begin
            m_off = 0;
            if (md == 3) m_up = 1'b1;
        end else if (md == 3 && m_off > S) begin
            m_off = 0;
            m_up  = 1'b1;
        end else if (md == 0) begin
            if (st != 0) m_off = (m_off + 1) % L;
        end else if (tk) begin
            if (md == 1) m_off = (m_off + 1) % L;
            else if (md == 2) m_off = (m_off + L - 1) % L;
            else if (S == 0) m_off = 0;
            else if (m_up) begin
                if (m_off < S) m_off++;
                else begin m_up = 1'b0; m_off--; end
            end else begin
                if (m_off > 0) m_off--;
                else begin m_up = 1'b1; m_off = 1; end
            end
        end
        if (we != 0) m_buf[wa] = wd;
        m_cnt = (m_cnt + 1) % TD;
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (bus.offset !== mon_e.off) begin
                errors++;
                $display("FAIL offset @%0t: got %0d expected %0d", $time, bus.offset, mon_e.off);
            end
            checks++;
            if (bus.tick !== mon_e.tck) begin
                errors++;
                $display("FAIL tick @%0t: got %0b expected %0b", $time, bus.tick, mon_e.tck);
            end
            checks++;
            if (bus.seg_out !== mon_e.seg) begin
                errors++;
                $display("FAIL seg_out @%0t: got %h expected %h", $time, bus.seg_out, mon_e.seg);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.msg_len = 5'd16;
        bus.mode    = 2'b00;
        bus.step    = 1'b0;
`ifdef SEG_SCROLL_BLINK_EN
        bus.blink_mask = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Reset state and first prescaler period in hold.
        repeat (6) cycle();

        // Load 0..5, then scroll left with L=6.
        for (int i = 0; i < 6; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 4'(i);
            bus.wr_data = 4'(i);
            cycle();
        end
        bus.wr_en   = 1'b0;
        bus.msg_len = 5'd6;
        bus.mode    = 2'b01;
        repeat (30) cycle();

        // Right scroll briefly, then bounce with L=7, then L=3.
        bus.mode = 2'b10;
        repeat (12) cycle();
        bus.msg_len = 5'd7;
        bus.mode    = 2'b11;
        repeat (44) cycle();
        bus.msg_len = 5'd3;
        repeat (12) cycle();

        // Hold: step to offset 5, then three single pulses, then idle ticks.
        bus.mode    = 2'b00;
        bus.msg_len = 5'd6;
        for (int i = 0; i < 10 && m_off != 5; i++) begin
            bus.step = 1'b1;
            cycle();
            bus.step = 1'b0;
            cycle();
        end
        repeat (3) begin
            bus.step = 1'b1;
            cycle();
            bus.step = 1'b0;
            cycle();
        end
        bus.step = 1'b1;
        repeat (3) cycle();
        bus.step = 1'b0;
        repeat (12) cycle();

        // Write 'A' to address 2 in a tick cycle while scrolling left.
        bus.mode = 2'b01;
        for (int i = 0; i < TD && m_cnt != TD - 1; i++) cycle();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd2;
        bus.wr_data = 4'hA;
        cycle();
        bus.wr_en = 1'b0;
        repeat (6) cycle();

        // Length shrink from 16 to 5 while offset is 9.
        bus.msg_len = 5'd16;
        guard = 0;
        while (m_off != 9 && guard < 200) begin
            cycle();
            guard++;
        end
        checks++;
        if (m_off != 9) begin
            errors++;
            $display("FAIL reach_offset9: got %0d expected 9", m_off);
        end
        bus.msg_len = 5'd5;
        repeat (8) cycle();

        // Zero and oversize lengths clamp.
        bus.msg_len = 5'd0;
        repeat (8) cycle();
        bus.msg_len = 5'd31;
        repeat (20) cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                bus.mode    = 2'($urandom_range(0, 3));
                bus.msg_len = 5'($urandom_range(0, 31));
            end
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_addr = 4'($urandom_range(0, MD - 1));
            bus.wr_data = 4'($urandom_range(0, 15));
            bus.step    = ($urandom_range(0, 3) == 0);
            cycle();
        end
        bus.wr_en = 1'b0;
        bus.step  = 1'b0;

        guard = 0;
        while (exp_q.size() > 0 && guard < 5) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
